hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Iterative multiply/divide unit owning the architectural HI/LO register pair of the MIPS core. It accepts MULT, MULTU, DIV and DIVU requests with a start/busy/done handshake, using the same 4-bit operation codes as the ALU's `alu_control`. It computes over 32 shift cycles and commits the 64-bit result into HI/LO. It also services MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO. The core stalls MFHI/MFLO, and any new mul/div, while `busy` is high.

## Interface
Parameters: none (datapath fixed at 32 bits).
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a mul/div operation; sampled only in IDLE
- `op`  in  4  4'b0000 MULT, 4'b1001 MULTU, 4'b1101 DIV, 4'b1100 DIVU; any other code with `start` is ignored
- `op1`  in  32  multiplicand / dividend (rs)
- `op2`  in  32  multiplier / divisor (rt)
- `mthi`  in  1  write `wdata` to HI
- `mtlo`  in  1  write `wdata` to LO
- `wdata`  in  32  MTHI/MTLO data
- `busy`  out  1  operation in progress (state != IDLE)
- `done`  out  1  one-cycle pulse: HI/LO just updated by a mul/div
- `hi`  out  32  HI register (remainder for div, upper product for mult)
- `lo`  out  32  LO register (quotient for div, lower product for mult)

## Operation
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, `start`=1 with a valid `op`:
  - Latch the operands. For signed ops, latch absolute values plus the sign flags.
  - Clear the iteration counter.
  - Go to MUL (MULT/MULTU) or DIV (DIV/DIVU).
- MUL: 32 shift-add iterations on the unsigned magnitudes (64-bit accumulator), then go to FIXUP.
- DIV: 32 restoring-division iterations on the magnitudes, producing a 32-bit quotient and remainder, then go to FIXUP.
- FIXUP applies sign correction, writes HI/LO, returns to IDLE and sets `done`.
  - MULT: negate the 64-bit product if sign(op1) != sign(op2).
  - DIV: negate the quotient if the signs differ. Give the remainder the sign of op1 (truncating division).
- Divide by zero (DIV or DIVU, op2 == 0): full latency; result forced to lo = 32'hFFFF_FFFF, hi = op1 (the original, unsigned-interpreted value).
- DIV 32'h8000_0000 / 32'hFFFF_FFFF gives lo = 32'h8000_0000, hi = 0 (wraps; no exception).
- MTHI/MTLO:
  - Accepted only in IDLE with `start`=0. The write occurs on the next edge.
  - `mthi` and `mtlo` together write the same `wdata` to both registers.
  - Ignored while `busy`.
  - If `start` (valid op) and `mthi`/`mtlo` are asserted in the same IDLE cycle, `start` wins and the move is dropped.
- `start` while busy is ignored and does not queue. Operands may change after the start edge.
- `hi`/`lo` hold their old values throughout an operation. They change only at the FIXUP edge.

## Timing
- Reset (`rst_n`=0, asynchronous): state=IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, counter=0.
- Reset mid-operation aborts with no HI/LO update. After release, the unit is in IDLE.
- Let E0 be the edge sampling `start`.
- `busy` rises after E0.
- Iterations occur on edges E1..E32.
- FIXUP commits on E33.
- `busy`=1 for 33 cycles.
- `done`=1 and the new `hi`/`lo` are visible in the cycle after E33; `busy`=0 in that cycle.
- Back-to-back: a `start` during the `done` cycle is accepted (IDLE). Throughput is one op per 34 cycles.
- `done` is registered and never asserted for MTHI/MTLO or ignored starts.

## Test plan
- MULTU op1=32'hFFFF_FFFF, op2=32'hFFFF_FFFF -> busy high 33 cycles, done pulse; hi=32'hFFFF_FFFE, lo=32'h0000_0001. MULT -3×5 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1.
- DIVU 7/2 -> lo=3, hi=1. DIV -7/2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIV 7/-2 -> lo=32'hFFFF_FFFD, hi=1.
- DIV 32'h1234_5678/0 -> lo=32'hFFFF_FFFF, hi=32'h1234_5678 after full latency. DIV 32'h8000_0000/32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- Start MULTU 5×6, pulse `start` (DIVU) and `mthi` with wdata=1 at cycle 10 -> both ignored; result hi=0, lo=30; single done pulse.
- MTHI wdata=32'hDEAD_BEEF, then MTLO wdata=32'hCAFE_F00D -> hi/lo updated next edge, no done. Then `start` MULTU 2×3 together with `mtlo` 32'h1 -> lo=6, hi=0.
- Reset asserted at iteration 10 of DIVU after HI/LO=0x11/0x22 -> busy=0, done=0, hi=lo=0 immediately. A new DIVU 9/4 after release -> lo=2, hi=1.

Source files
------------

// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the core and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
    localparam int unsigned W = 32;

    logic         start;
    logic [3:0]   op;
    logic [W-1:0] op1;
    logic [W-1:0] op2;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    modport master (
        output start, op, op1, op2, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, op1, op2, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative 32-cycle multiply/divide unit that owns the HI/LO pair.
// Magnitudes are processed unsigned; signs are restored in a single FIXUP cycle.
module hilo_muldiv (
    input  logic         clk,
    input  logic         rst_n,
    hilo_muldiv_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc;       // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [W-1:0]   opb;       // multiplicand or divisor magnitude
    logic [W-1:0]   op1_raw;
    logic           is_div, neg_res, neg_rem, div_zero;
    logic [W-1:0]   hi_q, lo_q;
    logic           busy_q, done_q;

    logic           op_valid_c, is_mul_op_c, signed_op_c, go_c;
    logic           s1_c, s2_c;
    logic [W-1:0]   mag1_c, mag2_c;
    logic [W:0]     mul_sum_c;
    logic [W:0]     div_shift_c;
    logic [W+1:0]   div_diff_c;
    logic [2*W-1:0] prod_c;
    logic [W-1:0]   quo_c, rem_c;
    logic [W-1:0]   fix_hi_c, fix_lo_c;

    // Opcode decode and operand magnitude capture
    always_comb begin
        op_valid_c  = 1'b0;
        is_mul_op_c = 1'b0;
        signed_op_c = 1'b0;
        case (bus.op)
            OP_MULT:  begin op_valid_c = 1'b1; is_mul_op_c = 1'b1; signed_op_c = 1'b1; end
            OP_MULTU: begin op_valid_c = 1'b1; is_mul_op_c = 1'b1; end
            OP_DIV:   begin op_valid_c = 1'b1; signed_op_c = 1'b1; end
            OP_DIVU:  begin op_valid_c = 1'b1; end
            default:  ;
        endcase
        go_c   = bus.start && op_valid_c;
        s1_c   = signed_op_c && bus.op1[W-1];
        s2_c   = signed_op_c && bus.op2[W-1];
        mag1_c = s1_c ? W'(-bus.op1) : bus.op1;
        mag2_c = s2_c ? W'(-bus.op2) : bus.op2;
    end

    // One shift-add step and one restoring-division step
    always_comb begin
        mul_sum_c   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : (W+1)'(0));
        div_shift_c = {acc[2*W-1:W], acc[W-1]};
        div_diff_c  = {1'b0, div_shift_c} - {2'b00, opb};
    end

    // Sign correction and divide-by-zero override applied at FIXUP
    always_comb begin
        prod_c   = neg_res ? (2*W)'(-acc) : acc;
        quo_c    = neg_res ? W'(-acc[W-1:0]) : acc[W-1:0];
        rem_c    = neg_rem ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
        fix_hi_c = prod_c[2*W-1:W];
        fix_lo_c = prod_c[W-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi_c = op1_raw;
                fix_lo_c = '1;
            end else begin
                fix_hi_c = rem_c;
                fix_lo_c = quo_c;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (go_c) state_n = is_mul_op_c ? MUL : DIV;
            MUL, DIV: if (cnt == CW'(W-1)) state_n = FIXUP;
            FIXUP:    state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Datapath, HI/LO and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op1_raw  <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_n != IDLE);
            done_q <= (state == FIXUP);
            case (state)
                IDLE: begin
                    if (go_c) begin
                        cnt      <= '0;
                        acc      <= {W'(0), mag1_c};
                        opb      <= mag2_c;
                        op1_raw  <= bus.op1;
                        is_div   <= !is_mul_op_c;
                        neg_res  <= s1_c ^ s2_c;
                        neg_rem  <= s1_c;
                        div_zero <= !is_mul_op_c && (bus.op2 == W'(0));
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                MUL: begin
                    acc <= {mul_sum_c, acc[W-1:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    if (!div_diff_c[W+1]) acc <= {div_diff_c[W-1:0], acc[W-2:0], 1'b1};
                    else                  acc <= {div_shift_c[W-1:0], acc[W-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                end
                FIXUP: begin
                    hi_q <= fix_hi_c;
                    lo_q <= fix_lo_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: vector table plus hand sequences for moves, ignored starts and reset.
module tb_hilo_muldiv;
    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b1001;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1100;
    localparam int NV = 11;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
        string       nm;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   passed = 0;
    logic [31:0] m_hi, m_lo;
    vec_t vecs [NV];

    hilo_muldiv_if bus ();
    hilo_muldiv dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: plain; 1: start/mthi pulsed mid-operation; 2: mtlo asserted with start
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input string nm, input int mode);
        int bc;
        int dn;
        bus.start = 1'b1; bus.op = o; bus.op1 = a; bus.op2 = b;
        if (mode == 2) begin bus.mtlo = 1'b1; bus.wdata = 32'h1; end
        tick();
        bus.start = 1'b0; bus.mtlo = 1'b0;
        bus.op1 = $urandom; bus.op2 = $urandom;
        chk({nm, " busy_rise"}, 64'(bus.busy), 64'd1);
        bc = 1; dn = 0;
        while (bus.busy && bc < 100) begin
            if (mode == 1 && bc == 10) begin
                bus.start = 1'b1; bus.op = OP_DIVU; bus.op1 = 32'd8; bus.op2 = 32'd2;
                bus.mthi = 1'b1; bus.wdata = 32'h1;
            end
            tick();
            bus.start = 1'b0; bus.mthi = 1'b0;
            if (bus.done) dn++;
            if (bus.busy) begin
                bc++;
                if (bc == 20) begin
                    chk({nm, " hi_hold"}, 64'(bus.hi), 64'(m_hi));
                    chk({nm, " lo_hold"}, 64'(bus.lo), 64'(m_lo));
                end
            end
        end
        chk({nm, " busy_cycles"}, 64'(bc), 64'd33);
        chk({nm, " done"}, 64'(bus.done), 64'd1);
        chk({nm, " hi"}, 64'(bus.hi), 64'(ehi));
        chk({nm, " lo"}, 64'(bus.lo), 64'(elo));
        tick();
        if (bus.done) dn++;
        chk({nm, " done_pulses"}, 64'(dn), 64'd1);
        m_hi = ehi; m_lo = elo;
    endtask

    initial begin
        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5"};
        vecs[2]  = '{OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         "divu_7_2"};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2"};
        vecs[4]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_7_m2"};
        vecs[5]  = '{OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, "div_by0"};
        vecs[6]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf"};
        vecs[7]  = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         "mult_m1m1"};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0"};
        vecs[9]  = '{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         "multu_2p32"};
        vecs[10] = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu_100_7"};

        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.op1 = '0; bus.op2 = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);
        chk("rst hi", 64'(bus.hi), 64'd0);
        chk("rst lo", 64'(bus.lo), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].nm, 0);

        // Start and move pulsed while busy are both ignored
        run_op(OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30, "ignore_busy", 1);

        // Invalid opcode with start does nothing
        bus.start = 1'b1; bus.op = 4'b0010; bus.op1 = 32'd3; bus.op2 = 32'd3;
        tick();
        bus.start = 1'b0;
        chk("badop busy", 64'(bus.busy), 64'd0);
        tick();
        chk("badop done", 64'(bus.done), 64'd0);
        chk("badop lo", 64'(bus.lo), 64'(m_lo));

        // MTHI then MTLO
        bus.mthi = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        tick();
        bus.mthi = 1'b0;
        chk("mthi hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        chk("mthi lo", 64'(bus.lo), 64'(m_lo));
        chk("mthi done", 64'(bus.done), 64'd0);
        bus.mtlo = 1'b1; bus.wdata = 32'hCAFE_F00D;
        tick();
        bus.mtlo = 1'b0;
        chk("mtlo lo", 64'(bus.lo), 64'h0000_0000_CAFE_F00D);
        chk("mtlo hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        chk("mtlo done", 64'(bus.done), 64'd0);
        m_hi = 32'hDEAD_BEEF; m_lo = 32'hCAFE_F00D;

        // Start wins over a simultaneous move
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, "start_wins", 2);

        // Reset in the middle of a divide
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'h11;
        tick();
        bus.mthi = 1'b0; bus.wdata = 32'h22;
        tick();
        bus.mtlo = 1'b0;
        chk("pre_rst hi", 64'(bus.hi), 64'h11);
        chk("pre_rst lo", 64'(bus.lo), 64'h22);
        bus.start = 1'b1; bus.op = OP_DIVU; bus.op1 = 32'd100; bus.op2 = 32'd7;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        chk("mid busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(bus.busy), 64'd0);
        chk("abort done", 64'(bus.done), 64'd0);
        chk("abort hi", 64'(bus.hi), 64'd0);
        chk("abort lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_hi = '0; m_lo = '0;
        run_op(OP_DIVU, 32'd9, 32'd4, 32'd1, 32'd2, "post_rst", 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
